// File: rtl/cpu_execute_stage.sv
// RV32 execute stage: drives the ALU operands, resolves branches and jumps,
// and holds one instruction for memory/writeback behind a valid/ready handshake.
module cpu_execute_stage #(
    parameter logic [31:0] RESET_PC_TARGET = 32'h0
) (
    input  logic        i_clock,
    input  logic        i_reset,
    input  logic        i_valid,
    output logic        o_ready,
    input  logic [31:0] i_pc,
    input  logic [31:0] i_rs1,
    input  logic [31:0] i_rs2,
    input  logic [31:0] i_imm,
    input  logic [3:0]  i_alu_op,
    input  logic        i_op1_sel,
    input  logic        i_op2_sel,
    input  logic [1:0]  i_result_sel,
    input  logic [4:0]  i_rd,
    input  logic        i_branch,
    input  logic        i_jal,
    input  logic        i_jalr,
    input  logic        i_mem_read,
    input  logic        i_mem_write,
    output logic [3:0]  o_alu_op,
    output logic [31:0] o_alu_op1,
    output logic [31:0] o_alu_op2,
    input  logic [31:0] i_alu_result,
    input  logic [31:0] i_alu_shift_result,
    input  logic [31:0] i_alu_signed_sum,
    input  logic        i_alu_compare_result,
    output logic        o_valid,
    input  logic        i_ready,
    output logic [4:0]  o_rd,
    output logic [31:0] o_rd_value,
    output logic [31:0] o_mem_address,
    output logic [31:0] o_mem_wdata,
    output logic        o_mem_read,
    output logic        o_mem_write,
    output logic        o_redirect,
    output logic [31:0] o_redirect_target,
    output logic [31:0] o_executed_count
);

    logic        accept;
    logic        drop;
    logic        load;
    logic        taken;
    logic [31:0] pc_plus4;
    logic [31:0] branch_target;
    logic [31:0] target;
    logic [31:0] result;

    assign o_ready   = !o_valid || i_ready;
    assign o_alu_op  = i_alu_op;
    assign o_alu_op1 = i_op1_sel ? i_pc : i_rs1;
    assign o_alu_op2 = i_op2_sel ? i_imm : i_rs2;

    // An accept during the redirect cycle is a wrong-path fetch.
    assign accept = i_valid && o_ready;
    assign drop   = accept && o_redirect;
    assign load   = accept && !drop;

    assign pc_plus4      = i_pc + 32'd4;
    assign branch_target = i_pc + i_imm;

    always_comb begin
        taken  = i_jal || i_jalr || (i_branch && i_alu_compare_result);
        target = branch_target;
        if (i_jalr) begin
            target = i_alu_signed_sum & ~32'h1;
        end
    end

    always_comb begin
        result = i_alu_result;
        unique case (i_result_sel)
            2'd0: result = i_alu_result;
            2'd1: result = i_alu_shift_result;
            2'd2: result = {31'b0, i_alu_compare_result};
            2'd3: result = pc_plus4;
        endcase
    end

    always_ff @(posedge i_clock or posedge i_reset) begin
        if (i_reset) begin
            o_valid           <= 1'b0;
            o_rd              <= '0;
            o_rd_value        <= '0;
            o_mem_address     <= '0;
            o_mem_wdata       <= '0;
            o_mem_read        <= 1'b0;
            o_mem_write       <= 1'b0;
            o_redirect        <= 1'b0;
            o_redirect_target <= RESET_PC_TARGET;
            o_executed_count  <= '0;
        end else begin
            o_redirect <= load && taken;
            if (load) begin
                o_valid          <= 1'b1;
                o_rd             <= i_rd;
                o_rd_value       <= result;
                o_mem_address    <= i_alu_signed_sum;
                o_mem_wdata      <= i_rs2;
                o_mem_read       <= i_mem_read;
                o_mem_write      <= i_mem_write;
                o_executed_count <= o_executed_count + 32'd1;
                if (taken) begin
                    o_redirect_target <= target;
                end
            end else if (i_ready) begin
                o_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_cpu_execute_stage.sv
// Bench for cpu_execute_stage: vector table plus stall, redirect/drop and
// reset sequences, checked against a scoreboard of held instructions.
module tb_cpu_execute_stage;

    localparam logic [31:0] RST_TGT = 32'h8000_0000;

    localparam logic [3:0] ADD  = 4'd0;
    localparam logic [3:0] SUB  = 4'd1;
    localparam logic [3:0] SLT  = 4'd2;
    localparam logic [3:0] SLTU = 4'd3;
    localparam logic [3:0] XORO = 4'd4;
    localparam logic [3:0] ORO  = 4'd5;
    localparam logic [3:0] ANDO = 4'd6;
    localparam logic [3:0] SLL  = 4'd7;
    localparam logic [3:0] SRL  = 4'd8;
    localparam logic [3:0] SRA  = 4'd9;
    localparam logic [3:0] EQ   = 4'd10;
    localparam logic [3:0] NE   = 4'd11;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        i_valid = 1'b0;
    logic        o_ready;
    logic [31:0] i_pc = '0, i_rs1 = '0, i_rs2 = '0, i_imm = '0;
    logic [3:0]  i_alu_op = '0;
    logic        i_op1_sel = 1'b0, i_op2_sel = 1'b0;
    logic [1:0]  i_result_sel = '0;
    logic [4:0]  i_rd = '0;
    logic        i_branch = 1'b0, i_jal = 1'b0, i_jalr = 1'b0;
    logic        i_mem_read = 1'b0, i_mem_write = 1'b0;
    logic [3:0]  o_alu_op;
    logic [31:0] o_alu_op1, o_alu_op2;
    logic [31:0] alu_result, alu_shift, alu_sum;
    logic        alu_cmp;
    logic        o_valid;
    logic        i_ready = 1'b1;
    logic [4:0]  o_rd;
    logic [31:0] o_rd_value, o_mem_address, o_mem_wdata;
    logic        o_mem_read, o_mem_write, o_redirect;
    logic [31:0] o_redirect_target, o_executed_count;

    cpu_execute_stage #(.RESET_PC_TARGET(RST_TGT)) dut (
        .i_clock(clk), .i_reset(rst),
        .i_valid(i_valid), .o_ready(o_ready),
        .i_pc(i_pc), .i_rs1(i_rs1), .i_rs2(i_rs2), .i_imm(i_imm),
        .i_alu_op(i_alu_op), .i_op1_sel(i_op1_sel), .i_op2_sel(i_op2_sel),
        .i_result_sel(i_result_sel), .i_rd(i_rd),
        .i_branch(i_branch), .i_jal(i_jal), .i_jalr(i_jalr),
        .i_mem_read(i_mem_read), .i_mem_write(i_mem_write),
        .o_alu_op(o_alu_op), .o_alu_op1(o_alu_op1), .o_alu_op2(o_alu_op2),
        .i_alu_result(alu_result), .i_alu_shift_result(alu_shift),
        .i_alu_signed_sum(alu_sum), .i_alu_compare_result(alu_cmp),
        .o_valid(o_valid), .i_ready(i_ready),
        .o_rd(o_rd), .o_rd_value(o_rd_value),
        .o_mem_address(o_mem_address), .o_mem_wdata(o_mem_wdata),
        .o_mem_read(o_mem_read), .o_mem_write(o_mem_write),
        .o_redirect(o_redirect), .o_redirect_target(o_redirect_target),
        .o_executed_count(o_executed_count)
    );

    always #5 clk = ~clk;

    // Behavioural stand-in for the CPU ALU
    always_comb begin
        alu_sum = o_alu_op1 + o_alu_op2;
        alu_cmp = 1'b0;
        alu_shift = '0;
        case (o_alu_op)
            SLT:  alu_cmp = $signed(o_alu_op1) < $signed(o_alu_op2);
            SLTU: alu_cmp = o_alu_op1 < o_alu_op2;
            EQ:   alu_cmp = o_alu_op1 == o_alu_op2;
            NE:   alu_cmp = o_alu_op1 != o_alu_op2;
            default: alu_cmp = 1'b0;
        endcase
        case (o_alu_op)
            SLL: alu_shift = o_alu_op1 << o_alu_op2[4:0];
            SRL: alu_shift = o_alu_op1 >> o_alu_op2[4:0];
            SRA: alu_shift = $signed(o_alu_op1) >>> o_alu_op2[4:0];
            default: alu_shift = '0;
        endcase
        case (o_alu_op)
            ADD:  alu_result = o_alu_op1 + o_alu_op2;
            SUB:  alu_result = o_alu_op1 - o_alu_op2;
            XORO: alu_result = o_alu_op1 ^ o_alu_op2;
            ORO:  alu_result = o_alu_op1 | o_alu_op2;
            ANDO: alu_result = o_alu_op1 & o_alu_op2;
            SLL, SRL, SRA: alu_result = alu_shift;
            default: alu_result = {31'b0, alu_cmp};
        endcase
    end

    typedef struct {
        logic [31:0] pc, rs1, rs2, imm;
        logic [3:0]  op;
        logic        op1_sel, op2_sel;
        logic [1:0]  rsel;
        logic [4:0]  rd;
        logic        br, jal, jalr, mr, mw;
        logic [31:0] exp_value;
        logic        exp_taken;
        logic [31:0] exp_target;
    } tvec_t;

    typedef struct {
        logic [4:0]  rd;
        logic [31:0] value, addr, wdata;
        logic        mr, mw;
    } exp_t;

    int nvec = 0;
    int nerr = 0;

    exp_t        q[$];
    logic        m_valid = 1'b0;
    logic        m_redirect = 1'b0;
    logic [31:0] m_target = RST_TGT;
    logic [31:0] m_count = '0;

    tvec_t tab[10];
    tvec_t beq, jalr, jal;

    function automatic tvec_t mk(
        logic [31:0] pc, logic [31:0] rs1, logic [31:0] rs2,
        logic [31:0] imm, logic [3:0] op, logic s1, logic s2,
        logic [1:0] rsel, logic [4:0] rd, logic br, logic jl,
        logic jr, logic mr, logic mw, logic [31:0] ev,
        logic et, logic [31:0] etg);
        tvec_t v;
        v.pc = pc; v.rs1 = rs1; v.rs2 = rs2; v.imm = imm;
        v.op = op; v.op1_sel = s1; v.op2_sel = s2; v.rsel = rsel;
        v.rd = rd; v.br = br; v.jal = jl; v.jalr = jr;
        v.mr = mr; v.mw = mw;
        v.exp_value = ev; v.exp_taken = et; v.exp_target = etg;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic drive(tvec_t v, logic vld, logic rdy);
        i_valid = vld; i_ready = rdy;
        i_pc = v.pc; i_rs1 = v.rs1; i_rs2 = v.rs2; i_imm = v.imm;
        i_alu_op = v.op; i_op1_sel = v.op1_sel; i_op2_sel = v.op2_sel;
        i_result_sel = v.rsel; i_rd = v.rd;
        i_branch = v.br; i_jal = v.jal; i_jalr = v.jalr;
        i_mem_read = v.mr; i_mem_write = v.mw;
    endtask

    // One clock: checks before the edge, model update, checks after the edge
    task automatic step(tvec_t v, logic vld, logic rdy);
        logic        exp_ready, acc, drp;
        logic [31:0] op1, op2;
        exp_t        e;
        drive(v, vld, rdy);
        #1;
        op1 = v.op1_sel ? v.pc : v.rs1;
        op2 = v.op2_sel ? v.imm : v.rs2;
        exp_ready = !m_valid || rdy;
        check("o_ready", {31'b0, o_ready}, {31'b0, exp_ready});
        if (vld) begin
            check("alu_op1", o_alu_op1, op1);
            check("alu_op2", o_alu_op2, op2);
        end
        if (m_valid && !rdy) begin
            check("held_rd", {27'b0, o_rd}, {27'b0, q.size() > 0 ? q[0].rd : 5'd0});
            check("held_value", o_rd_value, q.size() > 0 ? q[0].value : 32'hx);
        end
        if (m_valid && rdy) begin
            if (q.size() == 0) begin
                nvec++; nerr++;
                $display("FAIL scoreboard: got empty queue expected entry");
            end else begin
                e = q.pop_front();
                check("rd", {27'b0, o_rd}, {27'b0, e.rd});
                check("rd_value", o_rd_value, e.value);
                check("mem_address", o_mem_address, e.addr);
                check("mem_wdata", o_mem_wdata, e.wdata);
                check("mem_rw", {30'b0, o_mem_read, o_mem_write}, {30'b0, e.mr, e.mw});
            end
        end
        acc = vld && exp_ready;
        drp = acc && m_redirect;
        @(posedge clk);
        if (acc && !drp) begin
            e.rd = v.rd; e.value = v.exp_value; e.addr = op1 + op2;
            e.wdata = v.rs2; e.mr = v.mr; e.mw = v.mw;
            q.push_back(e);
            m_valid = 1'b1;
            m_count = m_count + 32'd1;
            m_redirect = v.exp_taken;
            if (v.exp_taken) m_target = v.exp_target;
        end else begin
            m_redirect = 1'b0;
            if (rdy) m_valid = 1'b0;
        end
        #1;
        check("o_valid", {31'b0, o_valid}, {31'b0, m_valid});
        check("o_redirect", {31'b0, o_redirect}, {31'b0, m_redirect});
        check("redirect_target", o_redirect_target, m_target);
        check("executed_count", o_executed_count, m_count);
        @(negedge clk);
    endtask

    initial begin
        tab[0] = mk(32'h0, 5, 7, 0, ADD, 0, 0, 0, 3, 0, 0, 0, 0, 0, 12, 0, 0);
        tab[1] = mk(32'h4, 3, 10, 0, SUB, 0, 0, 0, 4, 0, 0, 0, 0, 0,
                    32'hFFFF_FFF9, 0, 0);
        tab[2] = mk(32'h8, 1, 0, 4, SLL, 0, 1, 1, 5, 0, 0, 0, 0, 0, 16, 0, 0);
        tab[3] = mk(32'hC, 32'h8000_0000, 4, 0, SRA, 0, 0, 1, 6, 0, 0, 0, 0, 0,
                    32'hF800_0000, 0, 0);
        tab[4] = mk(32'h10, 1, 32'hFFFF_FFFF, 0, SLTU, 0, 0, 2, 7, 0, 0, 0, 0, 0,
                    1, 0, 0);
        tab[5] = mk(32'h14, 1, 32'hFFFF_FFFF, 0, SLT, 0, 0, 2, 8, 0, 0, 0, 0, 0,
                    0, 0, 0);
        tab[6] = mk(32'h300, 9, 9, 32'h40, NE, 0, 0, 0, 0, 1, 0, 0, 0, 0,
                    0, 0, 0);
        tab[7] = mk(32'hFFFF_FFFC, 0, 0, 4, ADD, 1, 1, 3, 1, 0, 0, 0, 0, 0,
                    0, 0, 0);
        tab[8] = mk(32'h20, 32'h1000, 32'hDEAD_BEEF, 8, ADD, 0, 1, 0, 0,
                    0, 0, 0, 0, 1, 32'h1008, 0, 0);
        tab[9] = mk(32'h24, 32'h2000, 0, 32'hFFFF_FFFC, ADD, 0, 1, 0, 9,
                    0, 0, 0, 1, 0, 32'h1FFC, 0, 0);
        beq  = mk(32'h100, 3, 3, 32'h20, EQ, 0, 0, 0, 0, 1, 0, 0, 0, 0,
                  1, 1, 32'h120);
        jalr = mk(32'h200, 32'h1003, 0, 0, ADD, 0, 1, 3, 1, 0, 0, 1, 0, 0,
                  32'h204, 1, 32'h1002);
        jal  = mk(32'h400, 0, 0, 32'h80, ADD, 1, 1, 3, 1, 0, 1, 0, 0, 0,
                  32'h404, 1, 32'h480);

        rst = 1'b1;
        repeat (2) @(negedge clk);
        check("rst_valid", {31'b0, o_valid}, 32'd0);
        check("rst_count", o_executed_count, 32'd0);
        check("rst_target", o_redirect_target, RST_TGT);
        check("rst_rd_value", o_rd_value, 32'd0);
        rst = 1'b0;

        foreach (tab[i]) step(tab[i], 1'b1, 1'b1);
        step(tab[0], 1'b0, 1'b1);

        // downstream stall with a pending offer, then release
        step(tab[0], 1'b1, 1'b1);
        for (int i = 0; i < 4; i++) step(tab[1], 1'b1, 1'b0);
        step(tab[1], 1'b1, 1'b1);
        step(tab[0], 1'b0, 1'b1);

        // taken branch followed by a wrong-path offer
        step(beq, 1'b1, 1'b1);
        step(tab[2], 1'b1, 1'b1);
        step(tab[0], 1'b0, 1'b1);

        // taken jump under stall: pulse must not repeat
        step(jal, 1'b1, 1'b1);
        step(tab[3], 1'b1, 1'b0);
        step(tab[3], 1'b1, 1'b0);
        step(tab[3], 1'b1, 1'b1);
        step(tab[0], 1'b0, 1'b1);

        step(jalr, 1'b1, 1'b1);
        step(tab[0], 1'b0, 1'b1);
        step(tab[0], 1'b0, 1'b1);

        // asynchronous reset while holding a stalled instruction
        step(tab[4], 1'b1, 1'b1);
        drive(tab[0], 1'b0, 1'b0);
        #2 rst = 1'b1;
        #1;
        check("async_valid", {31'b0, o_valid}, 32'd0);
        check("async_count", o_executed_count, 32'd0);
        check("async_target", o_redirect_target, RST_TGT);
        check("async_redirect", {31'b0, o_redirect}, 32'd0);
        q.delete();
        m_valid = 1'b0; m_redirect = 1'b0;
        m_count = '0; m_target = RST_TGT;
        @(negedge clk);
        rst = 1'b0;
        step(tab[0], 1'b1, 1'b1);
        step(tab[0], 1'b0, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
